branch_predictor: RTL

//  Front-end direction/target predictor: direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.

---
 rtl/branch_predictor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit saturating counters) plus tagged BTB, with a
// saturating mispredict counter. Lookup is combinational; updates land on clk.
module bp_entry #(
  parameter int XLEN = 32,
  parameter int TAGW = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic            alloc_i,
  input  logic            taken_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic [XLEN-1:0] target_i,
  output logic            valid_o,
  output logic [TAGW-1:0] tag_o,
  output logic [XLEN-1:0] target_o,
  output logic [1:0]      ctr_o
);
  logic            valid_q;
  logic [TAGW-1:0] tag_q;
  logic [XLEN-1:0] target_q;
  logic [1:0]      ctr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= 2'b01;
    end else if (we_i) begin
      if (alloc_i) begin
        valid_q  <= 1'b1;
        tag_q    <= tag_i;
        target_q <= target_i;
        ctr_q    <= 2'b10;
      end else begin
        if (taken_i) begin
          target_q <= target_i;
          if (ctr_q != 2'b11) ctr_q <= ctr_q + 2'b01;
        end else if (ctr_q != 2'b00) begin
          ctr_q <= ctr_q - 2'b01;
        end
      end
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign target_o = target_q;
  assign ctr_o    = ctr_q;
endmodule

module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  output logic            mispredict,
  output logic [31:0]     mispredict_cnt
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [ENTRIES-1:0]           valid_w;
  logic [ENTRIES-1:0][TAGW-1:0] tag_w;
  logic [ENTRIES-1:0][XLEN-1:0] target_w;
  logic [ENTRIES-1:0][1:0]      ctr_w;
  logic [ENTRIES-1:0]           we_w;

  logic [IDXW-1:0] if_idx, upd_idx;
  logic [TAGW-1:0] if_tag, upd_tag;
  logic            upd_hit;
  logic [31:0]     mis_cnt_q, mis_cnt_d;
  logic            unused_pc_lsbs;

  assign if_idx  = if_pc[IDXW+1:2];
  assign if_tag  = if_pc[XLEN-1:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDXW+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  assign upd_hit = valid_w[upd_idx] && (tag_w[upd_idx] == upd_tag);

  // A not-taken miss must leave the entry untouched, so it gets no write enable.
  genvar i;
  generate
    for (i = 0; i < ENTRIES; i++) begin : g_ent
      assign we_w[i] = upd_valid && (upd_idx == IDXW'(i)) && (upd_hit || upd_taken);
      bp_entry #(.XLEN(XLEN), .TAGW(TAGW)) u_ent (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we_w[i]),
        .alloc_i  (!upd_hit),
        .taken_i  (upd_taken),
        .tag_i    (upd_tag),
        .target_i (upd_target),
        .valid_o  (valid_w[i]),
        .tag_o    (tag_w[i]),
        .target_o (target_w[i]),
        .ctr_o    (ctr_w[i])
      );
    end
  endgenerate

  assign pred_hit     = valid_w[if_idx] && (tag_w[if_idx] == if_tag);
  assign pred_taken   = pred_hit && ctr_w[if_idx][1];
  assign pred_next_pc = pred_taken ? target_w[if_idx] : (if_pc + XLEN'(4));

  assign mispredict = upd_valid && (upd_taken != upd_pred_taken);
  assign mis_cnt_d  = (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) ? mis_cnt_q + 32'd1 : mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_cnt_q <= '0;
    else        mis_cnt_q <= mis_cnt_d;
  end

  assign mispredict_cnt = mis_cnt_q;
endmodule
